bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one bus_master between N requesters, e.g. instruction fetch (port 0) and data access (port 1).
- Each requester sees the same start/ready word-transaction handshake that bus_master exposes.
- Requests are latched per port, serviced one at a time, and the master response is forwarded to the granted port with no added latency.

Parameters:
- N, 2, number of requester ports (2..8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_addr  in  N*30  word address per port; port i occupies bits [30i+29:30i].
- req_start  in  N  one-cycle request strobe per port.
- req_write  in  N  1 = write, 0 = read; sampled with req_start.
- req_data_rw  in  N*32  write data per port; sampled with req_start.
- req_ready  out  N  one-cycle completion pulse per port.
- req_data_rd  out  32  read data, broadcast to all ports; valid when the port's req_ready is high.
- req_overrun  out  N  sticky flag: start dropped because the port already had a pending request.
- m_addr  out  30  to bus_master addr.
- m_start  out  1  to bus_master start.
- m_write  out  1  to bus_master write.
- m_data_rw  out  32  to bus_master data_rw.
- m_ready  in  1  from bus_master ready.
- m_data_rd  in  32  from bus_master data_rd.
- busy  out  1  high when not in IDLE.

Behaviour:

Reset (rst low, asynchronous):
- pending, grant and req_overrun cleared.
- m_start = 0, m_write = 0, m_addr = 0, m_data_rw = 0.
- state = IDLE.
- rr_last = N-1, so port 0 has first priority.
- Reset mid-transaction discards all pending work; the bus_master must be reset by the same rst.

Per-port request latch:
- On req_start[i] with pending[i] = 0: capture addr, write and data_rw into slot i; set pending[i].
- On req_start[i] with pending[i] = 1 and not clearing that cycle: drop the request, set req_overrun[i]; the slot is unchanged.
- Clear and new start on the same edge: pending[i] is cleared then re-set with the new request, so it is accepted.

FSM (registered):
- IDLE: if any pending bit is set, choose the first pending port searching rr_last+1, rr_last+2, ... modulo N.
  - Load m_addr / m_write / m_data_rw from that slot, set grant, go to ISSUE.
  - A request latched this cycle is visible to arbitration next cycle, so minimum start-to-m_start latency is 2 cycles.
- ISSUE: m_start = 1 for exactly this cycle; go to WAIT.
- WAIT: hold m_addr / m_write / m_data_rw stable.
  - On m_ready = 1: clear pending[grant], set rr_last = grant, go to IDLE.

Response path (combinational):
- req_ready[i] = m_ready & (state == WAIT) & (grant == i).
- req_data_rd = m_data_rd.
- m_ready outside WAIT is ignored.

Other rules:
- busy = (state != IDLE).
- Issue spacing: the IDLE cycle after m_ready guarantees bus_master is back in its request state before the next m_start. Back-to-back transactions are 3 cycles plus master latency apart.
- Fairness: with all ports continuously pending, grants rotate 0,1,...,N-1,0. No port waits more than N-1 transactions.
- req_overrun is cleared only by reset.

Test Plan:
1. Single read: port 0 start, addr=0x0000100, write=0; master answers m_ready after 3 cycles with m_data_rd=0xDEADBEEF.
   -> m_start high 2 cycles after req_start with m_addr=0x0000100, m_write=0; req_ready[0] pulses with req_data_rd=0xDEADBEEF; req_ready[1] stays 0.
2. Simultaneous starts: port 0 write 0x11111111 @0x10 and port 1 read @0x20 on the same cycle, after reset.
   -> port 0 is issued first, then port 1; rr_last ends at 1.
   -> Repeat with both starting together again: port 0 is served again first. Its priority comes from round-robin rotation (rr_last=1 makes port 0 next in the search), not from a fixed priority.
3. Continuous contention: both ports re-issue start on every ready for 8 transactions.
   -> grants alternate 0,1,0,1,... and each port gets exactly 4 transactions.
4. Overrun: port 1 starts @0x30, then starts again @0x40 while still pending.
   -> req_overrun[1] = 1; the master sees only 0x30.
   -> A start issued in the same cycle as port 1's req_ready is accepted and issued next, with no overrun.
5. Reset mid-WAIT: drop rst low while in WAIT with port 0 pending.
   -> m_start = 0, busy = 0 and pending cleared immediately, without waiting for a clock edge; no req_ready pulse after release.
6. Stray m_ready in IDLE: pulse m_ready with no pending request.
   -> req_ready remains all-zero and the state stays IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one word-transaction bus master between
// N requesters. Each port latches one request at a time. Requests are issued
// to the master one after another, and the master response is forwarded
// combinationally to the port that holds the grant.
module bus_arbiter #(
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*30-1:0] req_addr,
  input  logic [N-1:0]    req_start,
  input  logic [N-1:0]    req_write,
  input  logic [N*32-1:0] req_data_rw,
  output logic [N-1:0]    req_ready,
  output logic [31:0]     req_data_rd,
  output logic [N-1:0]    req_overrun,
  output logic [29:0]     m_addr,
  output logic            m_start,
  output logic            m_write,
  output logic [31:0]     m_data_rw,
  input  logic            m_ready,
  input  logic [31:0]     m_data_rd,
  output logic            busy
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rrLast_q, rrLast_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  overrun_q, overrun_d;
  logic [29:0]   mAddr_q, mAddr_d;
  logic          mWrite_q, mWrite_d;
  logic [31:0]   mData_q, mData_d;

  logic [29:0]   slotAddr_q  [N];
  logic          slotWrite_q [N];
  logic [31:0]   slotData_q  [N];

  logic [N-1:0]  doneVec;
  logic [N-1:0]  accept;
  logic          pickFound;
  logic [GW-1:0] pickIdx;
  logic [GW-1:0] candIdx;

  // Completion pulse for the granted port; it also frees that port's slot
  always_comb begin
    doneVec = '0;
    if (state_q == WAIT && m_ready) begin
      doneVec[grant_q] = 1'b1;
    end
  end

  // A start is taken when the slot is empty or is being freed on this edge;
  // otherwise it is dropped and the sticky overrun flag records the drop
  always_comb begin
    accept    = req_start & (~pending_q | doneVec);
    pending_d = (pending_q & ~doneVec) | accept;
    overrun_d = overrun_q | (req_start & pending_q & ~doneVec);
  end

  // Capture address, direction and write data for every accepted start
  for (genvar g = 0; g < N; g++) begin : gSlot
    // Slot contents only matter while pending, so they need no reset
    always_ff @(posedge clk) begin
      if (accept[g]) begin
        slotAddr_q[g]  <= req_addr[30*g +: 30];
        slotWrite_q[g] <= req_write[g];
        slotData_q[g]  <= req_data_rw[32*g +: 32];
      end
    end
  end

  // Round-robin search: first pending port after the last one served
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 1; k <= N; k++) begin
      candIdx = GW'((int'(rrLast_q) + k) % N);
      if (!pickFound && pending_q[candIdx]) begin
        pickFound = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // Transaction sequencer: pick in IDLE, strobe in ISSUE, hold until ready
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rrLast_d = rrLast_q;
    mAddr_d  = mAddr_q;
    mWrite_d = mWrite_q;
    mData_d  = mData_q;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d  = pickIdx;
          mAddr_d  = slotAddr_q[pickIdx];
          mWrite_d = slotWrite_q[pickIdx];
          mData_d  = slotData_q[pickIdx];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (m_ready) begin
          rrLast_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops all pending work and gives port 0 first turn
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rrLast_q  <= GW'(N - 1);
      pending_q <= '0;
      overrun_q <= '0;
      mAddr_q   <= '0;
      mWrite_q  <= 1'b0;
      mData_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrLast_q  <= rrLast_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      mAddr_q   <= mAddr_d;
      mWrite_q  <= mWrite_d;
      mData_q   <= mData_d;
    end
  end

  assign m_start     = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign m_addr      = mAddr_q;
  assign m_write     = mWrite_q;
  assign m_data_rw   = mData_q;
  assign req_ready   = doneVec;
  assign req_data_rd = m_data_rd;
  assign req_overrun = overrun_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two ports. A small behavioural bus
// master answers each m_start after a programmable number of cycles and logs
// every transaction it is handed.
module tb_bus_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*30-1:0] req_addr;
  logic [N-1:0]    req_start;
  logic [N-1:0]    req_write;
  logic [N*32-1:0] req_data_rw;
  logic [N-1:0]    req_ready;
  logic [31:0]     req_data_rd;
  logic [N-1:0]    req_overrun;
  logic [29:0]     m_addr;
  logic            m_start;
  logic            m_write;
  logic [31:0]     m_data_rw;
  logic            m_ready;
  logic [31:0]     m_data_rd;
  logic            busy;

  logic            modelReady;
  logic            strayReady;
  int              latency = 3;
  logic [31:0]     nextReadData = 32'hDEADBEEF;
  logic [29:0]     issuedAddr[$];
  logic            issuedWrite[$];
  logic [31:0]     issuedData[$];
  int              readyOrder[$];
  int              total = 0;
  int              bad = 0;

  assign m_ready = modelReady | strayReady;

  bus_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_start(req_start), .req_write(req_write),
    .req_data_rw(req_data_rw), .req_ready(req_ready), .req_data_rd(req_data_rd),
    .req_overrun(req_overrun), .m_addr(m_addr), .m_start(m_start),
    .m_write(m_write), .m_data_rw(m_data_rw), .m_ready(m_ready),
    .m_data_rd(m_data_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bus master model: acts 1 time unit after each rising edge
  initial begin : masterModel
    int cnt;
    cnt = 0;
    modelReady = 1'b0;
    m_data_rd = '0;
    forever begin
      @(posedge clk);
      #1;
      modelReady = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else if (m_start && cnt == 0) begin
        issuedAddr.push_back(m_addr);
        issuedWrite.push_back(m_write);
        issuedData.push_back(m_data_rw);
        cnt = latency;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          modelReady = 1'b1;
          m_data_rd = nextReadData;
        end
      end
    end
  end

  task automatic setReq(input int port, input logic [29:0] addr, input logic wr, input logic [31:0] data);
    req_start[port] = 1'b1;
    req_addr[port*30 +: 30] = addr;
    req_write[port] = wr;
    req_data_rw[port*32 +: 32] = data;
  endtask

  task automatic doReset();
    rst = 1'b0;
    req_start = '0;
    strayReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic collectReadies(input int want, output bit ok);
    int got;
    got = 0;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      req_start = '0;
      if (req_ready !== '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) readyOrder.push_back(i);
        got++;
      end
      if (got >= want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++; if (m_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_start got=%0h exp=0", m_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h exp=0", busy); end
    total++; if (m_addr !== 30'h0) begin bad++; $display("[TB] FAIL reset_m_addr got=%0h exp=0", m_addr); end
    total++; if (m_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_write got=%0h exp=0", m_write); end
    total++; if (m_data_rw !== 32'h0) begin bad++; $display("[TB] FAIL reset_m_data_rw got=%0h exp=0", m_data_rw); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_ready got=%0b exp=00", req_ready); end
    total++; if (req_overrun !== 2'b00) begin bad++; $display("[TB] FAIL reset_overrun got=%0b exp=00", req_overrun); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int base;
    logic seen;
    latency = 3;
    nextReadData = 32'hDEADBEEF;
    base = issuedAddr.size();
    @(negedge clk);
    setReq(0, 30'h0000100, 1'b0, 32'h0);
    @(negedge clk);
    req_start = '0;
    total++; if (m_start !== 1'b0) begin bad++; $display("[TB] FAIL single_start_early got=%0h exp=0", m_start); end
    @(negedge clk);
    total++; if (m_start !== 1'b1) begin bad++; $display("[TB] FAIL single_start_latency got=%0h exp=1", m_start); end
    total++; if (m_addr !== 30'h0000100) begin bad++; $display("[TB] FAIL single_m_addr got=%0h exp=100", m_addr); end
    total++; if (m_write !== 1'b0) begin bad++; $display("[TB] FAIL single_m_write got=%0h exp=0", m_write); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%0h exp=1", busy); end
    @(negedge clk);
    total++; if (m_start !== 1'b0) begin bad++; $display("[TB] FAIL single_start_one_cycle got=%0h exp=0", m_start); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (req_ready !== '0) seen = 1'b1;
      else @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL single_ready_timeout got=%0h exp=1", seen); end
    total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL single_req_ready got=%0b exp=01", req_ready); end
    total++; if (req_data_rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_rdata got=%0h exp=deadbeef", req_data_rd); end
    total++; if (m_addr !== 30'h0000100) begin bad++; $display("[TB] FAIL single_addr_hold got=%0h exp=100", m_addr); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_after got=%0h exp=0", busy); end
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL single_ready_one_pulse got=%0b exp=00", req_ready); end
    total++; if (issuedAddr.size() !== base + 1) begin bad++; $display("[TB] FAIL single_issue_count got=%0d exp=%0d", issuedAddr.size(), base + 1); end
  endtask

  task automatic test_simultaneous();
    int ib;
    int rb;
    bit ok;
    doReset();
    ib = issuedAddr.size();
    rb = readyOrder.size();
    @(negedge clk);
    setReq(0, 30'h10, 1'b1, 32'h11111111);
    setReq(1, 30'h20, 1'b0, 32'h0);
    collectReadies(2, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL simul_timeout got=%0h exp=1", ok); end
    total++; if (readyOrder[rb] !== 0) begin bad++; $display("[TB] FAIL simul_first_port got=%0d exp=0", readyOrder[rb]); end
    total++; if (readyOrder[rb+1] !== 1) begin bad++; $display("[TB] FAIL simul_second_port got=%0d exp=1", readyOrder[rb+1]); end
    total++; if (issuedAddr[ib] !== 30'h10) begin bad++; $display("[TB] FAIL simul_addr0 got=%0h exp=10", issuedAddr[ib]); end
    total++; if (issuedWrite[ib] !== 1'b1) begin bad++; $display("[TB] FAIL simul_write0 got=%0h exp=1", issuedWrite[ib]); end
    total++; if (issuedData[ib] !== 32'h11111111) begin bad++; $display("[TB] FAIL simul_wdata0 got=%0h exp=11111111", issuedData[ib]); end
    total++; if (issuedAddr[ib+1] !== 30'h20) begin bad++; $display("[TB] FAIL simul_addr1 got=%0h exp=20", issuedAddr[ib+1]); end
    total++; if (issuedWrite[ib+1] !== 1'b0) begin bad++; $display("[TB] FAIL simul_write1 got=%0h exp=0", issuedWrite[ib+1]); end
    @(negedge clk);
    setReq(0, 30'h11, 1'b0, 32'h0);
    setReq(1, 30'h21, 1'b0, 32'h0);
    collectReadies(2, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL simul2_timeout got=%0h exp=1", ok); end
    total++; if (readyOrder[rb+2] !== 0) begin bad++; $display("[TB] FAIL simul2_first_port got=%0d exp=0", readyOrder[rb+2]); end
    total++; if (issuedAddr[ib+2] !== 30'h11) begin bad++; $display("[TB] FAIL simul2_addr got=%0h exp=11", issuedAddr[ib+2]); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int rb;
    int starts;
    int got;
    int cnt0;
    int cnt1;
    bit ok;
    doReset();
    rb = readyOrder.size();
    starts = 2;
    got = 0;
    cnt0 = 0;
    cnt1 = 0;
    ok = 1'b0;
    @(negedge clk);
    setReq(0, 30'h100, 1'b0, 32'h0);
    setReq(1, 30'h200, 1'b1, 32'hC0DE0000);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req_start = '0;
      if (req_ready !== '0) begin
        for (int i = 0; i < N; i++) begin
          if (req_ready[i] === 1'b1) begin
            readyOrder.push_back(i);
            if (i == 0) cnt0++; else cnt1++;
            if (starts < 8) begin
              setReq(i, 30'(256 * (i + 1) + starts), 1'(i), 32'hC0DE0000 + starts);
              starts++;
            end
          end
        end
        got++;
      end
      if (got >= 8) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL contend_timeout got=%0h exp=1", ok); end
    for (int k = 0; k < 8; k++) begin
      total++; if (readyOrder[rb+k] !== (k % 2)) begin bad++; $display("[TB] FAIL contend_order_%0d got=%0d exp=%0d", k, readyOrder[rb+k], k % 2); end
    end
    total++; if (cnt0 !== 4) begin bad++; $display("[TB] FAIL contend_count0 got=%0d exp=4", cnt0); end
    total++; if (cnt1 !== 4) begin bad++; $display("[TB] FAIL contend_count1 got=%0d exp=4", cnt1); end
    total++; if (req_overrun !== 2'b00) begin bad++; $display("[TB] FAIL contend_no_overrun got=%0b exp=00", req_overrun); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int ib;
    bit ok;
    doReset();
    ib = issuedAddr.size();
    @(negedge clk);
    setReq(1, 30'h30, 1'b0, 32'h0);
    @(negedge clk);
    req_start = '0;
    setReq(1, 30'h40, 1'b0, 32'h0);
    @(negedge clk);
    req_start = '0;
    total++; if (req_overrun !== 2'b10) begin bad++; $display("[TB] FAIL overrun_flag got=%0b exp=10", req_overrun); end
    collectReadies(1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL overrun_timeout got=%0h exp=1", ok); end
    repeat (10) @(negedge clk);
    total++; if (issuedAddr.size() !== ib + 1) begin bad++; $display("[TB] FAIL overrun_issue_count got=%0d exp=%0d", issuedAddr.size(), ib + 1); end
    total++; if (issuedAddr[ib] !== 30'h30) begin bad++; $display("[TB] FAIL overrun_addr got=%0h exp=30", issuedAddr[ib]); end
    total++; if (req_overrun !== 2'b10) begin bad++; $display("[TB] FAIL overrun_sticky got=%0b exp=10", req_overrun); end

    doReset();
    ib = issuedAddr.size();
    @(negedge clk);
    setReq(1, 30'h60, 1'b0, 32'h0);
    collectReadies(1, ok);
    setReq(1, 30'h70, 1'b1, 32'h77777777);
    collectReadies(1, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL sameedge_timeout got=%0h exp=1", ok); end
    total++; if (req_overrun !== 2'b00) begin bad++; $display("[TB] FAIL sameedge_overrun got=%0b exp=00", req_overrun); end
    total++; if (issuedAddr.size() !== ib + 2) begin bad++; $display("[TB] FAIL sameedge_count got=%0d exp=%0d", issuedAddr.size(), ib + 2); end
    total++; if (issuedAddr[ib+1] !== 30'h70) begin bad++; $display("[TB] FAIL sameedge_addr got=%0h exp=70", issuedAddr[ib+1]); end
    total++; if (issuedData[ib+1] !== 32'h77777777) begin bad++; $display("[TB] FAIL sameedge_wdata got=%0h exp=77777777", issuedData[ib+1]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int ib;
    logic quiet;
    doReset();
    latency = 10;
    ib = issuedAddr.size();
    @(negedge clk);
    setReq(0, 30'h80, 1'b0, 32'h0);
    @(negedge clk);
    req_start = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midwait_busy_before got=%0h exp=1", busy); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midwait_busy_async got=%0h exp=0", busy); end
    total++; if (m_start !== 1'b0) begin bad++; $display("[TB] FAIL midwait_m_start got=%0h exp=0", m_start); end
    total++; if (m_addr !== 30'h0) begin bad++; $display("[TB] FAIL midwait_m_addr got=%0h exp=0", m_addr); end
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready !== '0 || m_start !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("[TB] FAIL midwait_quiet got=%0h exp=1", quiet); end
    total++; if (issuedAddr.size() !== ib + 1) begin bad++; $display("[TB] FAIL midwait_issue_count got=%0d exp=%0d", issuedAddr.size(), ib + 1); end
    latency = 3;
  endtask

  task automatic test_stray_ready();
    doReset();
    @(negedge clk);
    strayReady = 1'b1;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL stray_req_ready got=%0b exp=00", req_ready); end
    @(negedge clk);
    strayReady = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stray_busy got=%0h exp=0", busy); end
    total++; if (m_start !== 1'b0) begin bad++; $display("[TB] FAIL stray_m_start got=%0h exp=0", m_start); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL stray_busy_later got=%0h exp=0", busy); end
  endtask

  // Test sequence
  initial begin
    rst = 1'b0;
    req_start = '0;
    req_write = '0;
    req_addr = '0;
    req_data_rw = '0;
    strayReady = 1'b0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_contention();
    test_overrun();
    test_reset_mid_wait();
    test_stray_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
